instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Fetch stage sitting directly upstream of instruction memory. It owns the program counter, drives the memory read address and captures the returned instruction word. Captured words go into a small prefetch buffer, which feeds decode through a valid/ready handshake. Taken branches, jumps and jr from later stages arrive as a redirect that reloads the PC and flushes the buffer.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset; must be word aligned.
BUF_DEPTH, 2, prefetch buffer entries; power of two, minimum 2.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_addr  output  32  read address to instruction memory; equals current PC
imem_data  input  32  instruction word from memory; combinational read of imem_addr in the same cycle
redirect_valid  input  1  load new PC this cycle (branch/jump/jr resolved)
redirect_pc  input  32  redirect target address
inst_valid  output  1  buffer head holds a valid instruction
inst_ready  input  1  decode accepts the head this cycle
inst  output  32  instruction at buffer head
inst_pc  output  32  address of inst
inst_pc_plus4  output  32  inst_pc + 4, modulo 2^32

Behaviour:
- Reset (sync, highest priority): pc <= RESET_PC; buffer emptied (count 0, pointers 0); inst_valid=0; inst, inst_pc and inst_pc_plus4 read 0 while empty. Reset wins over a simultaneous redirect_valid.
- imem_addr = pc, combinational from the PC register.
- pop = inst_valid & inst_ready.
- push = !redirect_valid & (count < BUF_DEPTH | pop).
- On push: write {pc, imem_data} at the tail, then pc <= pc + 4. PC wraps 32'hFFFFFFFC -> 32'h00000000.
- When the buffer is full and there is no pop: no push; pc holds, so imem_addr is stable.
- Push and pop in the same cycle: count unchanged, head and tail both advance. This is legal when full and when holding 1 entry.
- Redirect (priority over push and pop):
  - pc <= {redirect_pc[31:2], 2'b00}; misaligned low bits are silently cleared.
  - Buffer flushed (count 0); any pop in that cycle is discarded. Decode treats a redirect cycle as non-consuming.
- Latency:
  - First instruction after reset release: inst_valid high 1 cycle later.
  - After redirect: inst_valid low for exactly 1 cycle, then the target instruction is presented.
  - Steady state with inst_ready=1: one instruction per cycle, no bubbles.
- Outputs inst, inst_pc and inst_pc_plus4 come from registered buffer storage at the head pointer, so there is no combinational path from imem_data to inst.
- While inst_valid=1 and inst_ready=0, the head entry must remain stable.
- No entry is lost or duplicated across any mix of backpressure and pops.
- Counter widths: count is log2(BUF_DEPTH)+1 bits; pointers are log2(BUF_DEPTH) bits and wrap naturally.

Optional Feature:
IFU_STALL_COUNTER_EN
- Defined: adds output stall_count [31:0].
  - Cleared by reset.
  - Increments (wrapping) on every cycle where count==BUF_DEPTH & !pop & !redirect_valid, i.e. fetch was blocked by backpressure.
  - Redirect does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Memory model word at addr = 32'h20000000 + addr/4; RESET_PC=0; reset 2 cycles, then inst_ready=1 -> first valid 1 cycle after release; inst_pc 0,4,8,C with inst 20000000..20000003 on consecutive cycles; inst_pc_plus4 = inst_pc+4.
- After 3 instructions, inst_ready=0 for 5 cycles -> buffer fills to 2, imem_addr frozen (0x14), inst/inst_pc stable at 0xC. Resume -> sequence continues 0x10, 0x14 with no gap or repeat. With IFU_STALL_COUNTER_EN: stall_count=4.
- Full buffer, redirect_valid=1 with redirect_pc=0x40 and inst_ready=1 in the same cycle -> next cycle inst_valid=0, imem_addr=0x40. Following cycle inst_pc=0x40, inst=20000010; the popped-in-redirect entry is not consumed.
- redirect_pc=0x43 -> imem_addr=0x40, inst_pc=0x40.
- RESET_PC=32'hFFFFFFF8 -> inst_pc sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004; inst_pc_plus4 at FFFFFFFC is 0.
- Mid-stream: reset=1 and redirect_valid=1 (redirect_pc=0x80) together -> next cycle pc=RESET_PC, inst_valid=0, buffer empty; after release, fetch restarts at RESET_PC, not 0x80.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory and queues {pc, word} pairs for decode.
// Optional build macro IFU_STALL_COUNTER_EN adds a stall_count output counting backpressure-blocked cycles.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4
`ifdef IFU_STALL_COUNTER_EN
    ,
    output logic [31:0] stall_count
`endif
);

    localparam int unsigned      PTR_W   = $clog2(BUF_DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [31:0]      pc_r;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      buf_inst_r [BUF_DEPTH];
    logic [31:0]      buf_pc_r   [BUF_DEPTH];

    logic valid_s;
    logic full_s;
    logic pop_s;
    logic push_s;

    assign imem_addr  = pc_r;
    assign inst_valid = valid_s;

    // Handshake decode: a full buffer may still accept a word when the head leaves this cycle.
    always_comb begin
        valid_s = (count_r != '0);
        full_s  = (count_r == DEPTH_C);
        pop_s   = valid_s & inst_ready;
        push_s  = ~redirect_valid & (~full_s | pop_s);
    end

    // Head presentation; empty buffer reads as zero so stale entries never leak.
    always_comb begin
        if (valid_s) begin
            inst          = buf_inst_r[head_r];
            inst_pc       = buf_pc_r[head_r];
            inst_pc_plus4 = buf_pc_r[head_r] + 32'd4;
        end else begin
            inst          = 32'h0000_0000;
            inst_pc       = 32'h0000_0000;
            inst_pc_plus4 = 32'h0000_0000;
        end
    end

    // PC, pointers and occupancy; reset beats redirect, redirect beats push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r    <= RESET_PC;
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (redirect_valid) begin
            pc_r    <= redirect_pc & 32'hFFFF_FFFC;
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
                pc_r   <= pc_r + 32'd4;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            buf_inst_r[tail_r] <= imem_data;
            buf_pc_r[tail_r]   <= pc_r;
        end
    end

`ifdef IFU_STALL_COUNTER_EN
    logic [31:0] stall_count_r;
    assign stall_count = stall_count_r;

    // Counts cycles where a full buffer blocked fetch; survives redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_r <= 32'h0000_0000;
        end else if (full_s && !pop_s && !redirect_valid) begin
            stall_count_r <= stall_count_r + 32'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: two instances (RESET_PC 0 and FFFFFFF8) driven in lockstep,
// checked against a shifting-array reference model; directed test-plan steps then random traffic.
module tb_instruction_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_ready;

    logic [31:0] addr_a, data_a, inst_a, pc_a, pc4_a, stall_a;
    logic [31:0] addr_b, data_b, inst_b, pc_b, pc4_b, stall_b;
    logic        valid_a, valid_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_pc    [2];
    logic [31:0] m_qpc   [2][DEPTH];
    logic [31:0] m_qin   [2][DEPTH];
    int          m_n     [2];
    logic [31:0] m_stall [2];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2000_0000 + (a >> 2);
    endfunction

    assign data_a = mem_word(addr_a);
    assign data_b = mem_word(addr_b);

    instruction_fetch_unit dut_a (
        .clk(clk), .reset(reset), .imem_addr(addr_a), .imem_data(data_a),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(valid_a), .inst_ready(inst_ready), .inst(inst_a),
        .inst_pc(pc_a), .inst_pc_plus4(pc4_a)
`ifdef IFU_STALL_COUNTER_EN
        , .stall_count(stall_a)
`endif
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .reset(reset), .imem_addr(addr_b), .imem_data(data_b),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(valid_b), .inst_ready(inst_ready), .inst(inst_b),
        .inst_pc(pc_b), .inst_pc_plus4(pc4_b)
`ifdef IFU_STALL_COUNTER_EN
        , .stall_count(stall_b)
`endif
    );

`ifndef IFU_STALL_COUNTER_EN
    assign stall_a = 32'h0000_0000;
    assign stall_b = 32'h0000_0000;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: the buffer is an ordered list of {pc, word}; pops shift it, pushes append.
    task automatic model_update(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_n[k]     = 0;
                m_pc[k]    = (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
                m_stall[k] = 32'h0000_0000;
            end else if (rv) begin
                m_n[k]  = 0;
                m_pc[k] = {rpc[31:2], 2'b00};
            end else begin
                if (m_n[k] > 0 && rdy) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        m_qpc[k][i] = m_qpc[k][i+1];
                        m_qin[k][i] = m_qin[k][i+1];
                    end
                    m_n[k]--;
                end
                if (m_n[k] < DEPTH) begin
                    m_qpc[k][m_n[k]] = m_pc[k];
                    m_qin[k][m_n[k]] = mem_word(m_pc[k]);
                    m_n[k]++;
                    m_pc[k] = m_pc[k] + 32'd4;
                end else begin
                    m_stall[k] = m_stall[k] + 32'd1;
                end
            end
        end
    endtask

    task automatic check_dut(input int k, input logic [31:0] addr, input logic valid,
                             input logic [31:0] ins, input logic [31:0] ipc,
                             input logic [31:0] ipc4, input logic [31:0] stall);
        logic hv;
        hv = (m_n[k] > 0);
        check_eq($sformatf("addr%0d", k), addr, m_pc[k]);
        check_eq($sformatf("valid%0d", k), {31'd0, valid}, {31'd0, hv});
        check_eq($sformatf("inst%0d", k), ins, hv ? m_qin[k][0] : 32'h0000_0000);
        check_eq($sformatf("inst_pc%0d", k), ipc, hv ? m_qpc[k][0] : 32'h0000_0000);
        check_eq($sformatf("inst_pc4_%0d", k), ipc4, hv ? m_qpc[k][0] + 32'd4 : 32'h0000_0000);
`ifdef IFU_STALL_COUNTER_EN
        check_eq($sformatf("stall%0d", k), stall, m_stall[k]);
`else
        if (stall !== 32'h0000_0000) check_eq($sformatf("stall_tie%0d", k), stall, 32'h0000_0000);
`endif
    endtask

    task automatic tick_check();
        @(negedge clk);
        check_dut(0, addr_a, valid_a, inst_a, pc_a, pc4_a, stall_a);
        check_dut(1, addr_b, valid_b, inst_b, pc_b, pc4_b, stall_b);
    endtask

    task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        reset          = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        model_update(r, rv, rpc, rdy);
    endtask

    task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        tick_check();
        drive(r, rv, rpc, rdy);
    endtask

    initial begin
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);               // c1: empty after reset
        step(1'b0, 1'b0, 32'h0, 1'b1);               // c2: first valid
        tick_check();                                // c3
        check_eq("wrap_pc", pc_b, 32'hFFFF_FFFC);
        check_eq("wrap_pc4", pc4_b, 32'h0000_0000);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick_check();                                // c4
        check_eq("wrap_next", pc_b, 32'h0000_0000);
        check_eq("seq_pc8", pc_a, 32'h0000_0008);
        check_eq("seq_inst8", inst_a, 32'h2000_0002);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        tick_check();                                // c10: stalled full
        check_eq("stall_addr", addr_a, 32'h0000_0014);
        check_eq("stall_head", pc_a, 32'h0000_000C);
`ifdef IFU_STALL_COUNTER_EN
        check_eq("stall_cnt", stall_a, 32'd4);
`endif
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);               // c11: 0x10
        tick_check();                                // c12: 0x14, buffer full
        check_eq("resume_pc", pc_a, 32'h0000_0014);
        drive(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        tick_check();                                // c13: redirect bubble
        check_eq("redir_valid", {31'd0, valid_a}, 32'd0);
        check_eq("redir_addr", addr_a, 32'h0000_0040);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick_check();                                // c14: target presented
        check_eq("redir_pc", pc_a, 32'h0000_0040);
        check_eq("redir_inst", inst_a, 32'h2000_0010);
        drive(1'b0, 1'b1, 32'h0000_0043, 1'b1);
        tick_check();                                // c15: misaligned target
        check_eq("misalign_addr", addr_a, 32'h0000_0040);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick_check();                                // c16
        check_eq("misalign_pc", pc_a, 32'h0000_0040);
        drive(1'b1, 1'b1, 32'h0000_0080, 1'b1);
        tick_check();                                // c17: reset beats redirect
        check_eq("rst_redir_addr", addr_a, 32'h0000_0000);
        check_eq("rst_redir_valid", {31'd0, valid_a}, 32'd0);
        check_eq("rst_redir_addr_b", addr_b, 32'hFFFF_FFF8);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick_check();                                // c18
        check_eq("restart_pc", pc_a, 32'h0000_0000);
        check_eq("restart_pc_b", pc_b, 32'hFFFF_FFF8);
        drive(1'b0, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0,
                 $urandom,
                 ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0);
        end
        tick_check();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
